pmreg_wr_arbiter: RTL
=====================

// Module: pmreg_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one WIDTH-bit clock-enabled register (pmdff-style,
//  d/ce/clr) between NREQ requesters in the micro-processor datapath. Samples requests,
//  grants one requester per cycle, drives the register's ce and d, and reports the winner.
//  Sits between the control/execute units and the shared accumulator/operand register.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  WIDTH     4   register data width
//  LOCK_MAX  4   max consecutive locked grants (ARB_LOCK_EN only; 1..15)
// PORTS
//  clk       in   1            rising-edge clock
//  clr_n     in   1            reset, asynchronous, active-low
//  req       in   NREQ         write request, one bit per requester, level
//  wdata     in   NREQ*WIDTH   requester i data at [i*WIDTH +: WIDTH]
//  lock      in   NREQ         hold grant request (present only with ARB_LOCK_EN)
//  gnt       out  NREQ         one-hot grant, registered
//  gnt_id    out  3            encoded index of gnt, registered
//  reg_ce    out  1            clock enable to shared register, registered
//  reg_d     out  WIDTH        data to shared register, registered
//  busy      out  1            high when any req pending or grant active
// BEHAVIOUR
//  - Reset: one clock, async active-low reset. While clr_n=0: gnt=0, gnt_id=0, reg_ce=0,
//    reg_d=0, rr pointer=0, FSM=IDLE, lock counter=0. Reset mid-grant drops outputs at once.
//  - FSM: IDLE (no grant) / GRANT (gnt one-hot, reg_ce=1). Evaluated every posedge:
//    any req -> GRANT to winner; no req -> IDLE. Back-to-back grants allowed, one per cycle.
//  - Latency: req sampled at edge N -> gnt, gnt_id, reg_ce, reg_d valid after edge N
//    (visible during cycle N+1); register captures reg_d at edge N+1.
//  - reg_d = wdata slice of winner sampled at same edge as req; later wdata changes ignored.
//  - Arbitration: search starts at rr pointer, ascending, wraps NREQ-1 -> 0. After a grant
//    to i, pointer = (i+1) mod NREQ. Pointer unchanged in IDLE.
//  - Requester owns handshake: drop req the cycle gnt seen; a still-high req re-competes
//    at lowest priority (no starvation: any held req granted within NREQ cycles).
//  - req dropping before sampling produces no grant; no cancel of an issued grant.
//  - busy = |req | reg_ce (combinational OR of input and registered output).
//  - Invariants: gnt one-hot or zero; reg_ce == |gnt; gnt_id == index of gnt (0 when idle).
// CONFIGURATION
//  ARB_LOCK_EN defined: lock port present. If granted requester i has req[i]&lock[i] at the
//    next edge, grant stays on i (pointer frozen, other reqs wait), counter increments;
//    after LOCK_MAX consecutive grants to i, lock is ignored for one arbitration and the
//    pointer advances normally; counter clears on any non-locked arbitration or IDLE.
//  ARB_LOCK_EN undefined: no lock port, no counter; pure round-robin as above.
// TESTING (NREQ=4, WIDTH=4, LOCK_MAX=4)
//  1 clr_n=0 with req=4'hF -> gnt=0, reg_ce=0, reg_d=0; release -> first gnt=4'b0001.
//  2 req=4'b0100, wdata[11:8]=4'hA one cycle -> next cycle gnt=4'b0100, gnt_id=2,
//    reg_ce=1, reg_d=4'hA; cycle after: gnt=0, reg_ce=0.
//  3 req=4'hF held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... ; reg_ce=1 throughout.
//  4 pointer at 3, req=4'b1001 held -> grants 3,0,3,0 (wrap-around order).
//  5 clr_n pulsed low during GRANT -> gnt/reg_ce fall without clock; next grant from index 0.
//  6 ARB_LOCK_EN: req=4'b0011, lock[0]=1 held -> gnt 0 four cycles, then 1, then 0 again;
//    without macro same stimulus -> alternating 0,1,0,1.

Source files
------------

// File: rtl/pmreg_wr_arbiter.sv
// pmreg_wr_arbiter: round-robin write arbiter for a shared clock-enabled register.
// NREQ requesters compete each cycle. The winner's grant, index, register enable and
// data slice are all registered together, so the shared register captures reg_d on
// the edge after the grant appears.
// Optional feature macro ARB_LOCK_EN adds a lock input. With it, a granted requester
// can hold the grant for up to LOCK_MAX consecutive cycles.
module pmreg_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 4
`ifdef ARB_LOCK_EN
   ,
   parameter int LOCK_MAX = 4
`endif
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   wdata,
`ifdef ARB_LOCK_EN
   input  logic [NREQ-1:0]         lock,
`endif
   output logic [NREQ-1:0]         gnt,
   output logic [2:0]              gnt_id,
   output logic                    reg_ce,
   output logic [WIDTH-1:0]        reg_d,
   output logic                    busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [2:0]        gnt_id_q, gnt_id_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [WIDTH-1:0]  reg_d_q, reg_d_d;

   // Requests zero-extended to 8 bits so a 3-bit index is always in range.
   logic [7:0]        req_ext;
   assign req_ext = 8'(req);

   // Per-requester data slices, padded to 8 entries for the same reason.
   logic [WIDTH-1:0]  slice [8];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_slice
         if (gi < NREQ) begin : g_used
            assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign slice[gi] = '0;
         end
      end
   endgenerate

   // Round-robin search: first requester at or after the pointer, wrapping to 0.
   logic        win_found;
   logic [2:0]  win_idx;
   logic [3:0]  cand;
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + 4'(k);
         if (cand >= 4'(NREQ)) begin
            cand = cand - 4'(NREQ);
         end
         if (!win_found && req_ext[cand[2:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[2:0];
         end
      end
   end

   // The pointer moves to the slot just after the winner, wrapping at NREQ-1.
   logic [2:0]  ptr_inc;
   assign ptr_inc = (win_idx == 3'(NREQ-1)) ? 3'd0 : win_idx + 3'd1;

`ifdef ARB_LOCK_EN
   // lock_cnt_q counts locked re-grants beyond the first grant of a run.
   // The holder may keep the grant while the run is shorter than LOCK_MAX grants.
   logic [3:0]  lock_cnt_q, lock_cnt_d;
   logic [7:0]  lock_ext;
   logic        lock_hold;
   assign lock_ext  = 8'(lock);
   assign lock_hold = (state_q == GRANT) && req_ext[gnt_id_q] && lock_ext[gnt_id_q]
                      && (lock_cnt_q < 4'(LOCK_MAX-1));
`endif

   // Next-state logic: pick the grantee, then derive all registered outputs from it.
   logic        grant_now;
   logic [2:0]  sel;
   logic [7:0]  onehot8;
   always_comb begin
      state_d   = IDLE;
      gnt_d     = '0;
      gnt_id_d  = '0;
      ptr_d     = ptr_q;
      reg_d_d   = reg_d_q;
      grant_now = 1'b0;
      sel       = win_idx;
      onehot8   = '0;
`ifdef ARB_LOCK_EN
      lock_cnt_d = '0;
      if (lock_hold) begin
         // Locked re-grant: the pointer stays frozen so the others keep their turn.
         grant_now  = 1'b1;
         sel        = gnt_id_q;
         lock_cnt_d = lock_cnt_q + 4'd1;
      end else if (win_found) begin
         grant_now = 1'b1;
         ptr_d     = ptr_inc;
      end
`else
      if (win_found) begin
         grant_now = 1'b1;
         ptr_d     = ptr_inc;
      end
`endif
      if (grant_now) begin
         state_d  = GRANT;
         onehot8  = 8'd1 << sel;
         gnt_d    = onehot8[NREQ-1:0];
         gnt_id_d = sel;
         reg_d_d  = slice[sel];
      end
   end

   // State and output registers; clr_n clears them immediately, without a clock edge.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         ptr_q      <= '0;
         reg_d_q    <= '0;
`ifdef ARB_LOCK_EN
         lock_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         ptr_q      <= ptr_d;
         reg_d_q    <= reg_d_d;
`ifdef ARB_LOCK_EN
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign reg_ce = (state_q == GRANT);
   assign reg_d  = reg_d_q;
   assign busy   = (|req) | reg_ce;

endmodule
